// File: rtl/paralelo_serie_idle.sv
// Parallel-to-serial transmitter: sends SYNC_WORDS idle symbols after reset, then
// serializes accepted bytes MSB first, filling empty slots with IDLE_SYM.
module paralelo_serie_idle #(
  parameter int unsigned SYNC_WORDS = 4,
  parameter logic [7:0]  IDLE_SYM   = 8'hBC
) (
  input  logic       clk32f,
  input  logic       reset,
  input  logic [7:0] data_in,
  input  logic       valid_in,
  output logic       load,
  output logic       active,
  output logic       out
);

  typedef enum logic {ST_SYNC, ST_ACTIVE} state_t;

  localparam logic [3:0] SYNC_LAST = 4'(SYNC_WORDS - 1);

  state_t     state;
  logic [2:0] bit_cnt;
  logic [7:0] cur_word;
  logic [3:0] sync_cnt;
  logic       boundary;
  logic       sync_done;
  logic [7:0] next_word;

  assign boundary  = (bit_cnt == 3'd7);
  assign sync_done = (sync_cnt == SYNC_LAST);

  // Handshake: load is a strobe, not a ready. data_in/valid_in are sampled only on
  // the edge that closes a load=1 cycle; valid_in=0 there sends an idle word instead.
  assign load      = reset & boundary & ((state == ST_ACTIVE) | sync_done);
  assign next_word = (load && valid_in) ? data_in : IDLE_SYM;

  always_ff @(posedge clk32f or negedge reset) begin
    if (!reset) begin
      state    <= ST_SYNC;
      bit_cnt  <= 3'd0;
      sync_cnt <= 4'd0;
      cur_word <= IDLE_SYM;
      out      <= 1'b0;
      active   <= 1'b0;
    end else begin
      out     <= cur_word[3'd7 - bit_cnt];
      bit_cnt <= bit_cnt + 3'd1;
      if (boundary) begin
        cur_word <= next_word;
        if (state == ST_SYNC) begin
          sync_cnt <= sync_cnt + 4'd1;
          if (sync_done) begin
            state  <= ST_ACTIVE;
            active <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_paralelo_serie_idle.sv
// Bench for paralelo_serie_idle: random and directed bytes, bit-level scoreboard
// built from the edge-numbered word schedule of the transmitter.
module tb_paralelo_serie_idle;

  localparam int unsigned SYNC_WORDS = 4;
  localparam logic [7:0]  IDLE_SYM   = 8'hBC;
  localparam int          W          = 1;

  logic       clk32f;
  logic       reset;
  logic [7:0] data_in;
  logic       valid_in;
  logic       load;
  logic       active;
  logic       out;

  logic [W-1:0] exp_q[$];
  int           edge_n;
  int           checks;
  int           errors;

  paralelo_serie_idle #(
    .SYNC_WORDS(SYNC_WORDS),
    .IDLE_SYM  (IDLE_SYM)
  ) dut (
    .clk32f  (clk32f),
    .reset   (reset),
    .data_in (data_in),
    .valid_in(valid_in),
    .load    (load),
    .active  (active),
    .out     (out)
  );

  // clock / reset
  initial clk32f = 1'b0;
  always #5 clk32f = ~clk32f;

  initial begin
    #2ms;
    $display("FAIL timeout edge %0d", edge_n);
    $fatal(1, "simulation time limit reached");
  end

  // Reference model: the word sent in slot w is chosen in the cycle before edge 8w+8,
  // and only from slot SYNC_WORDS-1 onward is the upstream byte considered.
  function automatic bit load_model(input int e);
    return ((e + 1) % 8 == 0) && ((e + 1) >= 8 * int'(SYNC_WORDS));
  endfunction

  task automatic check(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %0b expected %0b at edge %0d", name, act, exp, edge_n);
    end
  endtask

  task automatic push_word(input logic [7:0] w);
    for (int i = 7; i >= 0; i--) exp_q.push_back(w[i]);
  endtask

  // driver tasks (always entered and left on a falling edge)
  task automatic drive(input logic v, input logic [7:0] d);
    valid_in = v;
    data_in  = d;
    if (load_model(edge_n)) push_word(v ? d : IDLE_SYM);
    @(negedge clk32f);
  endtask

  task automatic send_byte(input logic [7:0] d);
    for (int g = 0; g < 16 && !load_model(edge_n); g++)
      drive(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)));
    drive(1'b1, d);
  endtask

  task automatic do_reset(input int n);
    reset    = 1'b0;
    valid_in = 1'b0;
    #1;
    check("rst_out", out, 1'b0);
    check("rst_load", load, 1'b0);
    check("rst_active", active, 1'b0);
    exp_q.delete();
    repeat (n) @(negedge clk32f);
    reset = 1'b1;
    for (int i = 0; i < int'(SYNC_WORDS); i++) push_word(IDLE_SYM);
  endtask

  // monitor: one serial bit per edge after reset release
  always @(posedge clk32f) begin
    if (!reset) begin
      edge_n = 0;
    end else begin
      edge_n = edge_n + 1;
      #1;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL out_underflow actual %0b expected none at edge %0d", out, edge_n);
      end else begin
        check("out", out, exp_q.pop_front());
      end
      check("load", load, load_model(edge_n));
      check("active", active, edge_n >= 8 * int'(SYNC_WORDS));
    end
  end

  initial begin
    checks   = 0;
    errors   = 0;
    edge_n   = 0;
    reset    = 1'b0;
    valid_in = 1'b0;
    data_in  = 8'h00;
    @(negedge clk32f);
    do_reset(3);

    // first data byte right after the sync idles, with noise on non-load cycles
    send_byte(8'hA5);
    repeat (20) drive(1'b0, 8'($urandom_range(0, 255)));

    // back-to-back extremes and a literal idle symbol as data
    send_byte(8'h00);
    send_byte(8'hFF);
    send_byte(IDLE_SYM);
    send_byte(8'h5A);

    // valid only outside load cycles: must be ignored
    for (int i = 0; i < 24; i++) begin
      if (load_model(edge_n)) drive(1'b0, 8'h3C);
      else drive(1'b1, 8'h3C);
    end

    // in-order byte sequence
    for (int b = 1; b <= 16; b++) send_byte(8'(b));

    // fully random traffic
    repeat (400) drive(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)));

    // reset in the middle of a data word
    do_reset(2);
    send_byte(8'hFF);
    while (edge_n < 37) drive(1'b0, 8'h00);
    do_reset(3);
    repeat (6) send_byte(8'($urandom_range(0, 255)));
    repeat (40) drive(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
